preamble_tx: RTL and testbench

//  Transmit-side counterpart of the receive matched filter. Holds the same known chip

---
 rtl/preamble_tx_pkg.sv | 26 ++
 rtl/preamble_coef_regs.sv | 46 ++++
 rtl/preamble_tx.sv | 135 +++++++++++++
 tb/tb_preamble_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/preamble_tx_pkg.sv
// Shared definitions for the preamble transmitter and the receive matched filter:
// coefficient geometry, chip/pass counter widths and the transmitter FSM encoding.
package preamble_tx_pkg;

  localparam int NUM_WORDS      = 7;
  localparam int CHIPS_PER_WORD = 16;
  localparam int WORD_W         = 32;
  localparam int CSTATE_W       = 3;   // cstate = word index + 1, 0 = no target
  localparam int WORD_IDX_W     = 3;   // enough to address NUM_WORDS words
  localparam int CHIP_IDX_W     = 7;   // chip index within one pass
  localparam int PASS_W         = 4;   // remaining extra passes

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_t;

  // A set coefficient bit maps to +amp, a clear bit to -amp.
  function automatic logic signed [15:0] chip_level(input logic bit_val,
                                                    input logic signed [15:0] amp);
    return bit_val ? amp : -amp;
  endfunction

endpackage

// File: rtl/preamble_coef_regs.sv
// Coefficient register file: NUM_WORDS x 32-bit words written through the
// cstate/cwrite/cdata port while the transmitter is idle, read combinationally.
module preamble_coef_regs
  import preamble_tx_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_W-1:0]     cdata,
  input  logic [CSTATE_W-1:0]   cstate,
  input  logic                  cwrite,
  input  logic                  busy,
  input  logic [WORD_IDX_W-1:0] rd_idx,
  output logic [WORD_W-1:0]     rd_word
);

  logic [NUM_WORDS-1:0][WORD_W-1:0] word_bus;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      logic [WORD_W-1:0] word_reg;
      logic              wr_hit;

      // cstate is 1-based so that 0 can mean "no target"; writes are frozen while busy
      assign wr_hit = cwrite && !busy && (cstate == CSTATE_W'(gi + 1));

      // Per-word storage, cleared by reset
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          word_reg <= '0;
        else if (wr_hit)
          word_reg <= cdata;
      end

      assign word_bus[gi] = word_reg;
    end
  endgenerate

  // Combinational read; indices past the last word read as zero
  always_comb begin
    rd_word = '0;
    if (rd_idx < WORD_IDX_W'(NUM_WORDS))
      rd_word = word_bus[rd_idx];
  end

endmodule

// File: rtl/preamble_tx.sv
// Preamble transmitter: emits the loaded chip sequence as +/-AMP QPSK chips,
// one chip per txstrobe, repeated repeat_n+1 times, then pulses done.
module preamble_tx
  import preamble_tx_pkg::*;
#(
  parameter int                 SEQ_LEN = 112,
  parameter logic signed [15:0] AMP     = 16'sd8192
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WORD_W-1:0]        cdata,
  input  logic [CSTATE_W-1:0]      cstate,
  input  logic                     cwrite,
  input  logic                     start,
  input  logic [PASS_W-1:0]        repeat_n,
  input  logic                     txstrobe,
  output logic signed [15:0]       tx_i,
  output logic signed [15:0]       tx_q,
  output logic                     tx_valid,
  output logic                     busy,
  output logic                     done
);

  localparam logic [CHIP_IDX_W-1:0] LAST_CHIP = CHIP_IDX_W'(SEQ_LEN - 1);

  tx_state_t                 state_reg, state_next;
  logic [CHIP_IDX_W-1:0]     chip_reg, chip_next;
  logic [PASS_W-1:0]         pass_reg, pass_next;
  logic signed [15:0]        tx_i_reg, tx_i_next;
  logic signed [15:0]        tx_q_reg, tx_q_next;
  logic                      tx_valid_reg, tx_valid_next;
  logic                      busy_reg, busy_next;
  logic                      done_reg, done_next;

  logic [WORD_W-1:0]         cur_word;
  logic [15:0]               word_hi;
  logic [15:0]               word_lo;
  logic [3:0]                bit_sel;

  preamble_coef_regs u_coef (
    .clk     (clk),
    .reset   (reset),
    .cdata   (cdata),
    .cstate  (cstate),
    .cwrite  (cwrite),
    .busy    (busy_reg),
    .rd_idx  (chip_reg[CHIP_IDX_W-1:4]),
    .rd_word (cur_word)
  );

  // Chip k uses bit 15-(k%16) of each half-word, so the first chip is the MSB
  assign word_hi = cur_word[31:16];
  assign word_lo = cur_word[15:0];
  assign bit_sel = ~chip_reg[3:0];

  // State, counters and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      chip_reg     <= '0;
      pass_reg     <= '0;
      tx_i_reg     <= '0;
      tx_q_reg     <= '0;
      tx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      chip_reg     <= chip_next;
      pass_reg     <= pass_next;
      tx_i_reg     <= tx_i_next;
      tx_q_reg     <= tx_q_next;
      tx_valid_reg <= tx_valid_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // Next-state logic; ARMED and SEND share the emit path so chip 0 goes out on the
  // first strobe after start, and pass boundaries roll over without a gap
  always_comb begin
    state_next    = state_reg;
    chip_next     = chip_reg;
    pass_next     = pass_reg;
    tx_i_next     = tx_i_reg;
    tx_q_next     = tx_q_reg;
    tx_valid_next = 1'b0;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          pass_next  = repeat_n;
          chip_next  = '0;
          busy_next  = 1'b1;
          state_next = ST_ARMED;
        end
      end
      ST_ARMED, ST_SEND: begin
        if (txstrobe) begin
          tx_i_next     = chip_level(word_hi[bit_sel], AMP);
          tx_q_next     = chip_level(word_lo[bit_sel], AMP);
          tx_valid_next = 1'b1;
          if (chip_reg == LAST_CHIP) begin
            chip_next = '0;
            if (pass_reg != '0) begin
              pass_next  = pass_reg - PASS_W'(1);
              state_next = ST_SEND;
            end else begin
              state_next = ST_DONE;
            end
          end else begin
            chip_next  = chip_reg + CHIP_IDX_W'(1);
            state_next = ST_SEND;
          end
        end
      end
      ST_DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        tx_i_next  = '0;
        tx_q_next  = '0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign tx_i     = tx_i_reg;
  assign tx_q     = tx_q_reg;
  assign tx_valid = tx_valid_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_preamble_tx.sv
// Scoreboard bench for preamble_tx: the stimulus pushes expected chips (with the
// cycle they must appear) and expected done pulses; a monitor pops and compares.
module tb_preamble_tx;
  import preamble_tx_pkg::*;

  localparam int SEQ = 112;
  localparam int A   = 8192;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        cdata;
  logic [2:0]         cstate;
  logic               cwrite;
  logic               start;
  logic [3:0]         repeat_n;
  logic               txstrobe;
  logic signed [15:0] tx_i;
  logic signed [15:0] tx_q;
  logic               tx_valid;
  logic               busy;
  logic               done;

  preamble_tx dut (
    .clk      (clk),
    .reset    (rst),
    .cdata    (cdata),
    .cstate   (cstate),
    .cwrite   (cwrite),
    .start    (start),
    .repeat_n (repeat_n),
    .txstrobe (txstrobe),
    .tx_i     (tx_i),
    .tx_q     (tx_q),
    .tx_valid (tx_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int i;
    int q;
  } chip_t;

  chip_t       exp_q[$];
  int          done_q[$];
  logic [31:0] model_w [NUM_WORDS];
  int          total = 0;
  int          bad = 0;
  int          n_chips = 0;
  bit          mon_on = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected chip k from the bench's own copy of the coefficient words
  function automatic chip_t model_chip(input int k, input int c);
    chip_t e;
    int w, b;
    w = k / 16;
    b = 15 - (k % 16);
    e.cyc = c;
    e.i = model_w[w][16 + b] ? A : -A;
    e.q = model_w[w][b] ? A : -A;
    return e;
  endfunction

  // Monitor: every tx_valid and done pulse must match the head of its queue
  always @(negedge clk) begin : mon
    chip_t e;
    int dc;
    if (mon_on && !rst) begin
      if (tx_valid) begin
        n_chips++;
        $display("chip %0d t=%0d i=%0d q=%0d", n_chips, cyc, tx_i, tx_q);
        if (exp_q.size() == 0) begin
          chk("unexpected_chip", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("chip_cycle", cyc, e.cyc);
          chk("chip_i", int'(tx_i), e.i);
          chk("chip_q", int'(tx_q), e.q);
          chk("busy_on_chip", int'(busy), 1);
        end
      end
      if (done) begin
        $display("done t=%0d", cyc);
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          dc = done_q.pop_front();
          chk("done_cycle", cyc, dc);
          chk("busy_at_done", int'(busy), 0);
          chk("tx_i_at_done", int'(tx_i), 0);
          chk("tx_q_at_done", int'(tx_q), 0);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    cdata = '0; cstate = '0; cwrite = 1'b0; start = 1'b0;
    repeat_n = '0; txstrobe = 1'b0;
  endtask

  task automatic load(input int idx1, input logic [31:0] d);
    cstate = 3'(idx1); cdata = d; cwrite = 1'b1;
    step();
    cwrite = 1'b0; cstate = '0;
    model_w[idx1 - 1] = d;
  endtask

  // One run: start (with a simultaneous strobe that must be ignored, and an optional
  // idle-cycle coefficient write), then strobes. At chip evt_chip of pass 0 a second
  // start plus a write that must be ignored is issued. stop_chip>=0 aborts early.
  task automatic run_seq(input int rep, input int gap, input int lead,
                         input int st_cs, input logic [31:0] st_d,
                         input int evt_chip, input int evt_cs, input logic [31:0] evt_d,
                         input int stop_chip);
    int last_c, waitn, n;
    start = 1'b1; repeat_n = 4'(rep); txstrobe = 1'b1;
    if (st_cs != 0) begin
      cwrite = 1'b1; cstate = 3'(st_cs); cdata = st_d;
      model_w[st_cs - 1] = st_d;
    end
    step();
    start = 1'b0; txstrobe = 1'b0; cwrite = 1'b0; cstate = '0;
    chk("busy_after_start", int'(busy), 1);
    last_c = 0;
    n = 0;
    for (int p = 0; p <= rep; p++) begin
      for (int k = 0; k < SEQ; k++) begin
        if (stop_chip >= 0 && n == stop_chip) return;
        waitn = (p == 0 && k == 0) ? lead : gap - 1;
        for (int g = 0; g < waitn; g++) begin
          if (g == 0 && p == 0 && k == evt_chip) begin
            start = 1'b1; repeat_n = 4'hF;
            cwrite = 1'b1; cstate = 3'(evt_cs); cdata = evt_d;
          end
          step();
          start = 1'b0; cwrite = 1'b0; cstate = '0;
        end
        txstrobe = 1'b1;
        exp_q.push_back(model_chip(k, cyc + 1));
        last_c = cyc;
        step();
        txstrobe = 1'b0;
        n++;
      end
    end
    done_q.push_back(last_c + 2);
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && (exp_q.size() != 0 || done_q.size() != 0); t++) step();
    chk("chips_outstanding", exp_q.size(), 0);
    chk("done_outstanding", done_q.size(), 0);
    chk("idle_busy", int'(busy), 0);
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_tx_i"}, int'(tx_i), 0);
    chk({tag, "_tx_q"}, int'(tx_q), 0);
    chk({tag, "_tx_valid"}, int'(tx_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    clear_inputs();
    foreach (model_w[w]) model_w[w] = '0;
    rst = 1'b1;
    repeat (3) step();
    check_zero_outputs("reset");
    rst = 1'b0;
    step();
    mon_on = 1'b1;

    // Test 1: alternating pattern, one pass, strobe every 16 clks
    for (int w = 1; w <= NUM_WORDS; w++) load(w, 32'hAAAA_5555);
    run_seq(0, 16, 1, 0, '0, -1, 0, '0, -1);
    drain();
    // Strobes while idle must not produce chips
    for (int s = 0; s < 5; s++) begin
      txstrobe = 1'b1; step(); txstrobe = 1'b0; step();
    end
    chk("idle_strobe_no_chip", exp_q.size(), 0);

    // Test 2: three passes back to back, exact chip count
    base = n_chips;
    run_seq(2, 3, 1, 0, '0, -1, 0, '0, -1);
    drain();
    chk("three_pass_chip_count", n_chips - base, 3 * SEQ);

    // Test 3: write to word 7 while busy is ignored; then cstate=3 write in the start cycle
    run_seq(0, 2, 1, 0, '0, 20, 7, 32'h0000_0000, -1);
    drain();
    run_seq(0, 2, 1, 3, 32'hFFFF_0000, -1, 0, '0, -1);
    drain();

    // Test 4: strobe 5 clks after start; second start and cstate=0 write during SEND
    base = n_chips;
    run_seq(0, 4, 5, 0, '0, 30, 0, 32'h1234_5678, -1);
    drain();
    chk("second_start_chip_count", n_chips - base, SEQ);

    // Test 5: reset after 50 chips clears everything including coefficients
    run_seq(0, 2, 1, 0, '0, -1, 0, '0, 50);
    step();
    step();
    chk("chips_before_reset", exp_q.size(), 0);
    rst = 1'b1;
    step();
    check_zero_outputs("midreset");
    exp_q.delete();
    done_q.delete();
    foreach (model_w[w]) model_w[w] = '0;
    rst = 1'b0;
    step();
    // Cleared words: every chip is -AMP on both rails
    run_seq(0, 2, 1, 0, '0, -1, 0, '0, -1);
    drain();
    for (int w = 1; w <= NUM_WORDS; w++) load(w, 32'hAAAA_5555);
    run_seq(0, 2, 1, 0, '0, -1, 0, '0, -1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
